// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle for seg_display_arbiter: two request channels in,
// grant pulses and the latched digit/dot/ownership view out.
interface seg_display_arbiter_if;
  logic        req_a;
  logic [15:0] data_a;
  logic [3:0]  dots_a;
  logic        gnt_a;
  logic        req_b;
  logic [15:0] data_b;
  logic [3:0]  dots_b;
  logic        gnt_b;
  logic [3:0]  dig_3, dig_2, dig_1, dig_0;
  logic        dot_3, dot_2, dot_1, dot_0;
  logic [1:0]  owner;
  logic        locked;

  modport master (
    output req_a, data_a, dots_a, req_b, data_b, dots_b,
    input  gnt_a, gnt_b, dig_3, dig_2, dig_1, dig_0, dot_3, dot_2, dot_1, dot_0,
    input  owner, locked
  );

  modport slave (
    input  req_a, data_a, dots_a, req_b, data_b, dots_b,
    output gnt_a, gnt_b, dig_3, dig_2, dig_1, dig_0, dot_3, dot_2, dot_1, dot_0,
    output owner, locked
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for a shared 4-digit seven-segment display with a
// minimum owner dwell time and round-robin resolution of simultaneous requests.
module seg_display_arbiter #(
  parameter int unsigned DWELL = 100_000_000,
  parameter int unsigned CW    = 27
) (
  input logic                  clk,
  input logic                  rst_n,
  seg_display_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDwell, StFree} state_e;

  localparam logic [1:0]    OwnNone = 2'b00;
  localparam logic [1:0]    OwnA    = 2'b01;
  localparam logic [1:0]    OwnB    = 2'b10;
  localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;  // 0: A wins the next tie, 1: B wins
  logic [1:0]    owner_q, owner_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dots_q, dots_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          locked_q, locked_d;

  logic own_is_a, own_req, oth_req;
  logic lat_a, lat_b;

  assign own_is_a = (owner_q == OwnA);
  assign own_req  = own_is_a ? bus.req_a : bus.req_b;
  assign oth_req  = own_is_a ? bus.req_b : bus.req_a;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    disp_d  = disp_q;
    dots_d  = dots_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    lat_a   = 1'b0;
    lat_b   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_a && bus.req_b) begin
          lat_a   = ~rr_q;
          lat_b   = rr_q;
          owner_d = rr_q ? OwnB : OwnA;
          rr_d    = ~rr_q;
          count_d = '0;
          state_d = StDwell;
        end else if (bus.req_a || bus.req_b) begin
          lat_a   = bus.req_a;
          lat_b   = bus.req_b;
          owner_d = bus.req_a ? OwnA : OwnB;
          count_d = '0;
          state_d = StDwell;
        end
      end
      StDwell: begin
        // Owner may stream updates, but the dwell window is never restarted.
        lat_a = own_req && own_is_a;
        lat_b = own_req && !own_is_a;
        if (count_q == LastCnt) begin
          state_d = StFree;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      StFree: begin
        if (oth_req) begin
          lat_a   = !own_is_a;
          lat_b   = own_is_a;
          owner_d = own_is_a ? OwnB : OwnA;
          rr_d    = !own_is_a;
          count_d = '0;
          state_d = StDwell;
        end else begin
          lat_a = own_req && own_is_a;
          lat_b = own_req && !own_is_a;
        end
      end
      default: state_d = StIdle;
    endcase

    if (lat_a) begin
      disp_d  = bus.data_a;
      dots_d  = bus.dots_a;
      gnt_a_d = 1'b1;
    end else if (lat_b) begin
      disp_d  = bus.data_b;
      dots_d  = bus.dots_b;
      gnt_b_d = 1'b1;
    end

    locked_d = (state_d == StDwell);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rr_q     <= 1'b0;
      owner_q  <= OwnNone;
      disp_q   <= '0;
      dots_q   <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      disp_q   <= disp_d;
      dots_q   <= dots_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      locked_q <= locked_d;
    end
  end

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.dig_3  = disp_q[15:12];
  assign bus.dig_2  = disp_q[11:8];
  assign bus.dig_1  = disp_q[7:4];
  assign bus.dig_0  = disp_q[3:0];
  assign bus.dot_3  = dots_q[3];
  assign bus.dot_2  = dots_q[2];
  assign bus.dot_1  = dots_q[1];
  assign bus.dot_0  = dots_q[0];
  assign bus.owner  = owner_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic, all
// checked against a time-stamp based ownership model.
module tb_seg_display_arbiter;

  localparam int unsigned Dwell = 4;

  logic clk;
  logic rst_n;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .DWELL(Dwell),
    .CW   (3)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner id (0 none, 1 A, 2 B), edge at which it took over.
  int          m_owner;
  int          m_take;
  int          m_edge;
  bit          m_ptr;  // 0: A wins next tie
  logic [15:0] m_disp;
  logic [3:0]  m_dots;
  logic        m_gnt_a, m_gnt_b, m_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check("disp", 32'({bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0}), 32'(m_disp));
    check("dots", 32'({bus.dot_3, bus.dot_2, bus.dot_1, bus.dot_0}), 32'(m_dots));
    check("gnt_a", 32'(bus.gnt_a), 32'(m_gnt_a));
    check("gnt_b", 32'(bus.gnt_b), 32'(m_gnt_b));
    check("owner", 32'(bus.owner), 32'(m_owner));
    check("locked", 32'(bus.locked), 32'(m_locked));
  endtask

  task automatic model_reset();
    m_owner = 0; m_take = 0; m_ptr = 1'b0;
    m_disp = '0; m_dots = '0;
    m_gnt_a = 1'b0; m_gnt_b = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_show(input int who, input logic [15:0] da, input logic [15:0] db,
                            input logic [3:0] oa, input logic [3:0] ob);
    if (who == 1) begin m_disp = da; m_dots = oa; m_gnt_a = 1'b1; end
    else          begin m_disp = db; m_dots = ob; m_gnt_b = 1'b1; end
  endtask

  task automatic model_edge(input logic ra, input logic rb, input logic [15:0] da,
                            input logic [15:0] db, input logic [3:0] oa, input logic [3:0] ob);
    int own, oth;
    logic own_r, oth_r;
    m_edge++;
    m_gnt_a = 1'b0;
    m_gnt_b = 1'b0;
    if (m_owner == 0) begin
      if (ra || rb) begin
        own = (ra && rb) ? (m_ptr ? 2 : 1) : (ra ? 1 : 2);
        if (ra && rb) m_ptr = !m_ptr;
        m_owner = own; m_take = m_edge;
        model_show(own, da, db, oa, ob);
      end
    end else begin
      own   = m_owner;
      oth   = 3 - own;
      own_r = (own == 1) ? ra : rb;
      oth_r = (own == 1) ? rb : ra;
      // Switching is allowed once the owner has held for a full dwell window.
      if (oth_r && (m_edge - 1 - m_take >= int'(Dwell))) begin
        m_ptr = (own == 2);
        m_owner = oth; m_take = m_edge;
        model_show(oth, da, db, oa, ob);
      end else if (own_r) begin
        model_show(own, da, db, oa, ob);
      end
    end
    m_locked = (m_owner != 0) && (m_edge - m_take < int'(Dwell));
  endtask

  task automatic step(input logic ra, input logic rb, input logic [15:0] da,
                      input logic [15:0] db, input logic [3:0] oa, input logic [3:0] ob);
    @(negedge clk);
    bus.req_a = ra; bus.data_a = da; bus.dots_a = oa;
    bus.req_b = rb; bus.data_b = db; bus.dots_b = ob;
    model_edge(ra, rb, da, db, oa, ob);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic step_rnd(input logic ra, input logic rb);
    step(ra, rb, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // Reset is asserted mid-cycle so its asynchronous effect is observed.
  task automatic do_reset();
    @(negedge clk);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_a = 1'b0; bus.data_a = '0; bus.dots_a = '0;
    bus.req_b = 1'b0; bus.data_b = '0; bus.dots_b = '0;
    m_edge = 0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single A request with known data
    step(1'b1, 1'b0, 16'h1234, 16'h5555, 4'b0001, 4'b1111);
    check("t1_disp", 32'({bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0}), 32'h1234);
    check("t1_dot0", 32'(bus.dot_0), 32'd1);
    // B pulse during dwell is ignored, then B takes over once free
    step(1'b0, 1'b1, 16'h0000, 16'hBEEF, 4'h0, 4'hA);
    for (int i = 0; i < 4; i++) step_rnd(1'b0, 1'b0);
    check("t2_free", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b1, 16'h0000, 16'hBEEF, 4'h0, 4'hA);
    check("t2_beef", 32'({bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0}), 32'hBEEF);
    // Owner B idles well past the dwell window
    for (int i = 0; i < 25; i++) step_rnd(1'b0, 1'b0);

    // Continuous contention alternates owners
    do_reset();
    for (int i = 0; i < 24; i++) step_rnd(1'b1, 1'b1);

    // A streams incrementing data
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'(16'h0100 + i), 16'hFFFF, 4'(i), 4'hF);

    // Async reset in the middle of a dwell
    do_reset();
    step_rnd(1'b1, 1'b0);
    step_rnd(1'b0, 1'b0);
    do_reset();

    // Random traffic with varying request density
    for (int i = 0; i < 400; i++) begin
      int unsigned dens;
      dens = (i / 50) % 4;
      step_rnd(($urandom_range(3) < dens) ? 1'b1 : 1'b0,
               ($urandom_range(3) < dens) ? 1'b1 : 1'b0);
      if (i == 217) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
